program_counter: RTL and testbench

//   Program counter for the single-cycle RV32I core; holds the fetch address (pc_reg).

---
 rtl/program_counter.sv | 75 +++++++
 tb/tb_program_counter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Fetch-address register for the single-cycle RV32I core: selects seq/branch/JAL/JALR next PC.
// pc_reg updates one edge after its inputs; finish_flag or a misaligned target holds the PC.
module program_counter #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                IMEM_BYTES   = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            finish_flag,
    input  logic [1:0]      pc_sel,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] pc_reg,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] pc_next,
    output logic            misaligned,
    output logic            out_of_range,
    output logic            halted
);

    localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_BYTES);
    localparam logic [XLEN-1:0] FOUR       = XLEN'(4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;

    assign pc_plus4 = pc_q + FOUR;
    assign pc_rel   = pc_q + imm;
    assign jalr_sum = rs1_val + imm;

    always_comb begin
        target = pc_plus4;
        case (pc_sel)
            2'b00:   target = pc_plus4;
            2'b01:   target = branch_taken ? pc_rel : pc_plus4;
            2'b10:   target = pc_rel;
            2'b11:   target = {jalr_sum[XLEN-1:1], 1'b0};
            default: target = pc_plus4;
        endcase
    end

    assign pc_next    = target;
    assign misaligned = |target[1:0];

    // finish_flag outranks the misalignment hold; both leave pc_q untouched
    always_comb begin
        pc_d     = pc_q;
        halted_d = 1'b0;
        if (finish_flag) begin
            halted_d = 1'b1;
        end else if (!misaligned) begin
            pc_d = target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_VECTOR;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    assign pc_reg       = pc_q;
    assign halted       = halted_q;
    assign out_of_range = (pc_q >= IMEM_LIMIT);

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: spec-level reference model checked every cycle,
// plus literal expectations at the points the directed vectors are hand-computed.
module tb_program_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        finish_flag;
    logic [1:0]  pc_sel;
    logic        branch_taken;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] pc_reg;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        misaligned;
    logic        out_of_range;
    logic        halted;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_valid = 1'b0;

    program_counter #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0000_0000),
        .IMEM_BYTES  (1024)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .finish_flag (finish_flag),
        .pc_sel      (pc_sel),
        .branch_taken(branch_taken),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .pc_reg      (pc_reg),
        .pc_plus4    (pc_plus4),
        .pc_next     (pc_next),
        .misaligned  (misaligned),
        .out_of_range(out_of_range),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference target straight from the ISA rules
    function automatic logic [31:0] ref_target(input logic [1:0] sel, input logic bt,
                                               input logic [31:0] pc, input logic [31:0] im,
                                               input logic [31:0] rs1);
        logic [31:0] t;
        if (sel == 2'd3)                     t = (rs1 + im) & 32'hFFFF_FFFE;
        else if (sel == 2'd2)                t = pc + im;
        else if (sel == 2'd1 && bt)          t = pc + im;
        else                                 t = pc + 32'd4;
        return t;
    endfunction

    // One clock: apply inputs, check combinational/registered outputs, then step model
    task automatic cyc(input logic rst, input logic fin, input logic [1:0] sel,
                       input logic bt, input logic [31:0] im, input logic [31:0] rs1);
        logic [31:0] t;
        logic        mis;
        reset = rst; finish_flag = fin; pc_sel = sel; branch_taken = bt;
        imm = im; rs1_val = rs1;
        #1;
        if (m_valid) begin
            t   = ref_target(sel, bt, m_pc, im, rs1);
            mis = (t % 4) != 0;
            chk("pc_reg",       pc_reg,               m_pc);
            chk("pc_plus4",     pc_plus4,             m_pc + 32'd4);
            chk("pc_next",      pc_next,              t);
            chk("misaligned",   {31'd0, misaligned},  {31'd0, mis});
            chk("out_of_range", {31'd0, out_of_range}, {31'd0, (m_pc >= 32'd1024)});
            chk("halted",       {31'd0, halted},      {31'd0, m_halted});
        end else begin
            t   = 32'd0;
            mis = 1'b0;
        end
        @(posedge clk);
        if (rst) begin
            m_pc = 32'd0; m_halted = 1'b0; m_valid = 1'b1;
        end else if (fin) begin
            m_halted = 1'b1;
        end else begin
            m_halted = 1'b0;
            if (!mis) m_pc = t;
        end
        @(negedge clk);
    endtask

    task automatic seq(); cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0); endtask
    task automatic jalr(input logic [31:0] rs1); cyc(1'b0, 1'b0, 2'd3, 1'b0, 32'd0, rs1); endtask

    initial begin
        reset = 1'b1; finish_flag = 1'b0; pc_sel = 2'd0; branch_taken = 1'b0;
        imm = '0; rs1_val = '0;
        @(negedge clk);

        // reset then four sequential fetches
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        chk("reset_pc", pc_reg, 32'h0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        seq(); chk("seq_4",  pc_reg, 32'h4);
        seq(); chk("seq_8",  pc_reg, 32'h8);
        seq(); chk("seq_c",  pc_reg, 32'hC);
        seq(); chk("seq_10", pc_reg, 32'h10);

        // mid-run reset
        seq(); chk("pre_rst_14", pc_reg, 32'h14);
        cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0); chk("midrst_0", pc_reg, 32'h0);
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);  chk("midrst_hold", pc_reg, 32'h0);
        for (int i = 0; i < 4; i++) seq();
        chk("back_10", pc_reg, 32'h10);

        // finish_flag holds for five edges, then resumes
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 2'd0, 1'b0, 32'd0, 32'd0);
            chk("fin_hold", pc_reg, 32'h10);
            chk("fin_halted", {31'd0, halted}, 32'd1);
        end
        seq(); chk("fin_release", pc_reg, 32'h14);
        chk("fin_unhalt", {31'd0, halted}, 32'd0);

        // branch / JAL
        cyc(1'b0, 1'b0, 2'd2, 1'b0, 32'h0C, 32'd0); chk("jal_20", pc_reg, 32'h20);
        cyc(1'b0, 1'b0, 2'd1, 1'b1, 32'hFFFF_FFF8, 32'd0); chk("br_taken", pc_reg, 32'h18);
        cyc(1'b0, 1'b0, 2'd2, 1'b0, 32'h08, 32'd0); chk("jal_back", pc_reg, 32'h20);
        cyc(1'b0, 1'b0, 2'd1, 1'b0, 32'hFFFF_FFF8, 32'd0); chk("br_not", pc_reg, 32'h24);
        jalr(32'h20); chk("jalr_20", pc_reg, 32'h20);
        cyc(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0); chk("jal_120", pc_reg, 32'h120);

        // JALR bit-0 clear and misalignment hold
        pc_sel = 2'd3; rs1_val = 32'h41; imm = 32'd0; reset = 1'b0; finish_flag = 1'b0;
        #1 chk("jalr_next_40", pc_next, 32'h40);
        jalr(32'h41); chk("jalr_40", pc_reg, 32'h40);
        pc_sel = 2'd3; rs1_val = 32'h42;
        #1 chk("jalr_mis", {31'd0, misaligned}, 32'd1);
        jalr(32'h42); chk("mis_hold", pc_reg, 32'h40);
        cyc(1'b0, 1'b0, 2'd1, 1'b1, 32'h2, 32'd0); chk("br_mis_hold", pc_reg, 32'h40);
        cyc(1'b0, 1'b0, 2'd1, 1'b0, 32'h2, 32'd0); chk("br_nt_ok", pc_reg, 32'h44);

        // wrap and out-of-range
        jalr(32'hFFFF_FFFC); chk("pc_top", pc_reg, 32'hFFFF_FFFC);
        chk("oor_top", {31'd0, out_of_range}, 32'd1);
        seq(); chk("wrap_0", pc_reg, 32'h0);
        jalr(32'h3FC); chk("oor_below", {31'd0, out_of_range}, 32'd0);
        seq(); chk("pc_400", pc_reg, 32'h400);
        chk("oor_at", {31'd0, out_of_range}, 32'd1);
        seq(); chk("oor_adv", pc_reg, 32'h404);

        // reset overrides finish_flag
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 32'd0, 32'd0);
        cyc(1'b1, 1'b1, 2'd0, 1'b0, 32'd0, 32'd0);
        chk("rst_over_fin_pc", pc_reg, 32'h0);
        chk("rst_over_fin_h", {31'd0, halted}, 32'd0);
        seq();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
